// File: rtl/gate_selftest_ctrl_pkg.sv
// Shared definitions for the gate self-test controller.
//   - FSM state encoding (IDLE/SETTLE/CHECK/DONE)
//   - golden gate-output table indexed by {a,b}
//   - bit positions of each gate inside the 7-bit gate_y bus
package gate_test_pkg;

  localparam int unsigned GATE_W  = 7;
  localparam int unsigned NUM_VEC = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Bit positions on gate_y
  localparam int unsigned AND_B  = 0;
  localparam int unsigned OR_B   = 1;
  localparam int unsigned NAND_B = 2;
  localparam int unsigned NOR_B  = 3;
  localparam int unsigned XOR_B  = 4;
  localparam int unsigned XNOR_B = 5;
  localparam int unsigned NOT_B  = 6;

  // Expected gate_y for each {a,b}
  localparam logic [GATE_W-1:0] GOLD_00 = 7'h6C;
  localparam logic [GATE_W-1:0] GOLD_01 = 7'h56;
  localparam logic [GATE_W-1:0] GOLD_10 = 7'h16;
  localparam logic [GATE_W-1:0] GOLD_11 = 7'h23;

  localparam logic [2:0] ERR_MAX  = 3'd4;
  localparam logic [1:0] LAST_IDX = 2'd3;

  function automatic logic [GATE_W-1:0] golden_y(input logic [1:0] idx);
    logic [GATE_W-1:0] y;
    unique case (idx)
      2'd0:    y = GOLD_00;
      2'd1:    y = GOLD_01;
      2'd2:    y = GOLD_10;
      default: y = GOLD_11;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_selftest_ctrl_if.sv
// Handshake and datapath bus between the self-test controller and its user.
//   start, abort   : run request / synchronous abort (user -> controller)
//   gate_y         : gate datapath outputs (datapath -> controller)
//   gate_a, gate_b : registered operands to the datapath
//   busy, done     : run in progress / one-cycle end-of-run pulse
//   pass, fail_mask, err_count, last_y : run results
// master = user/bench side, slave = controller side.
interface gate_selftest_ctrl_if;
  import gate_test_pkg::*;

  logic                 start;
  logic                 abort;
  logic [GATE_W-1:0]    gate_y;
  logic                 gate_a;
  logic                 gate_b;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_VEC-1:0]   fail_mask;
  logic [2:0]           err_count;
  logic [GATE_W-1:0]    last_y;

  modport master (
    output start, abort, gate_y,
    input  gate_a, gate_b, busy, done, pass, fail_mask, err_count, last_y
  );

  modport slave (
    input  start, abort, gate_y,
    output gate_a, gate_b, busy, done, pass, fail_mask, err_count, last_y
  );

endinterface

// File: rtl/gate_selftest_ctrl_golden_rom.sv
// Combinational golden table lookup: vector index {a,b} -> expected gate_y.
//   idx_i : vector index
//   exp_o : expected 7-bit gate output
module gate_golden_rom
  import gate_test_pkg::*;
(
  input  logic [1:0]        idx_i,
  output logic [GATE_W-1:0] exp_o
);

  always_comb begin
    exp_o = golden_y(idx_i);
  end

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Built-in self-test sequencer for the 2-input basic-gate datapath.
// Walks {a,b} through 00,01,10,11, waits SETTLE_CYCLES after driving each
// vector, compares gate_y with the golden table and records per-vector
// mismatches.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of gate_selftest_ctrl_if (start/abort/gate_y in,
//           operands, status and results out)
module gate_selftest_ctrl
  import gate_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_OUT       = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_selftest_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 gate_a_q, gate_b_q;
  logic                 pass_q;
  logic [NUM_VEC-1:0]   fail_mask_q;
  logic [2:0]           err_count_q;
  logic [NUM_OUT-1:0]   last_y_q;
  logic [NUM_OUT-1:0]   exp_y;
  logic                 mismatch;
  logic                 accept;
  logic                 busy;
  logic                 done_pulse;

  gate_golden_rom u_rom (
    .idx_i (idx_q),
    .exp_o (exp_y)
  );

  // Abort outranks start even in IDLE
  assign accept   = bus.start && !bus.abort;
  assign mismatch = (bus.gate_y != exp_y);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETTLE;
      SETTLE: begin
        if (bus.abort)          state_d = IDLE;
        else if (cnt_q == '0)   state_d = CHECK;
      end
      CHECK: begin
        if (bus.abort)               state_d = IDLE;
        else if (idx_q == LAST_IDX)  state_d = DONE;
        else                         state_d = SETTLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy       = (state_q != IDLE);
    done_pulse = (state_q == DONE);
  end

  // Datapath: operands, settle counter, result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      err_count_q <= '0;
      last_y_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= CNT_LOAD;
            fail_mask_q <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        CHECK: begin
          // An abort in CHECK leaves partial results untouched
          if (bus.abort) begin
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
          end else begin
            last_y_q <= bus.gate_y;
            if (mismatch) begin
              fail_mask_q[idx_q] <= 1'b1;
              if (err_count_q < ERR_MAX) err_count_q <= err_count_q + 3'd1;
            end
            if (idx_q != LAST_IDX) begin
              idx_q                <= idx_q + 2'd1;
              {gate_a_q, gate_b_q} <= idx_q + 2'd1;
              cnt_q                <= CNT_LOAD;
            end
          end
        end
        DONE: begin
          // fail_mask_q already holds the last vector's result here
          if (bus.abort) begin
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
          end else begin
            pass_q <= (fail_mask_q == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gate_a    = gate_a_q;
  assign bus.gate_b    = gate_b_q;
  assign bus.busy      = busy;
  assign bus.done      = done_pulse;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;
  assign bus.err_count = err_count_q;
  assign bus.last_y    = last_y_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: a behavioural gate datapath (with an optional
// stuck-at-0 on the AND output) feeds DUT A (SETTLE_CYCLES=2); DUT B
// (SETTLE_CYCLES=1) sees gate_y stuck at zero. Run expectations are queued
// when a run is started and popped by per-DUT monitors on done.
module tb_gate_selftest_ctrl;

  typedef struct {
    int unsigned t0;
    int unsigned lat;
    logic        pass;
    logic [3:0]  mask;
    logic [2:0]  err;
    logic [6:0]  ly;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fault_a;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic pend_a = 1'b0, pend_b = 1'b0;
  logic exp_pass_a, exp_pass_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_selftest_ctrl_if ifa ();
  gate_selftest_ctrl_if ifb ();

  gate_selftest_ctrl #(.SETTLE_CYCLES(2), .NUM_OUT(7)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  gate_selftest_ctrl #(.SETTLE_CYCLES(1), .NUM_OUT(7)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  function automatic logic [6:0] gates(input logic a, input logic b);
    return {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  assign ifa.gate_y = gates(ifa.gate_a, ifa.gate_b) & ~{6'b0, fault_a};
  assign ifb.gate_y = 7'h00;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_gate_a"},    ifa.gate_a,    0);
    chk({tag, "_gate_b"},    ifa.gate_b,    0);
    chk({tag, "_busy"},      ifa.busy,      0);
    chk({tag, "_done"},      ifa.done,      0);
    chk({tag, "_pass"},      ifa.pass,      0);
    chk({tag, "_fail_mask"}, ifa.fail_mask, 0);
    chk({tag, "_err_count"}, ifa.err_count, 0);
    chk({tag, "_last_y"},    ifa.last_y,    0);
  endtask

  // Starts a run on DUT A (sel=0) or B (sel=1) and queues its expected result
  task automatic start_run(input bit sel, input int unsigned lat, input logic p,
                           input logic [3:0] m, input logic [2:0] er, input logic [6:0] ly);
    exp_t e;
    @(negedge clk);
    e.t0 = cyc; e.lat = lat; e.pass = p; e.mask = m; e.err = er; e.ly = ly;
    if (sel) begin qb.push_back(e); ifb.start = 1'b1; end
    else     begin qa.push_back(e); ifa.start = 1'b1; end
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  // Starts a run on DUT A that is not expected to complete
  task automatic kick_a();
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pend_a) begin
      chk("a_pass", ifa.pass, exp_pass_a);
      chk("a_done_width", ifa.done, 0);
      pend_a = 1'b0;
    end else if (ifa.done) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_done", ifa.done, 0);
      end else begin
        e = qa.pop_front();
        chk("a_latency",   cyc - e.t0,    e.lat);
        chk("a_fail_mask", ifa.fail_mask, e.mask);
        chk("a_err_count", ifa.err_count, e.err);
        chk("a_last_y",    ifa.last_y,    e.ly);
        exp_pass_a = e.pass;
        pend_a = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (pend_b) begin
      chk("b_pass", ifb.pass, exp_pass_b);
      chk("b_done_width", ifb.done, 0);
      pend_b = 1'b0;
    end else if (ifb.done) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_done", ifb.done, 0);
      end else begin
        e = qb.pop_front();
        chk("b_latency",   cyc - e.t0,    e.lat);
        chk("b_fail_mask", ifb.fail_mask, e.mask);
        chk("b_err_count", ifb.err_count, e.err);
        chk("b_last_y",    ifb.last_y,    e.ly);
        exp_pass_b = e.pass;
        pend_b = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    fault_a = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_a("a_reset");
    chk("b_reset_busy",      ifb.busy,      0);
    chk("b_reset_fail_mask", ifb.fail_mask, 0);
    rst_n = 1'b1;

    // Healthy datapath
    start_run(1'b0, 13, 1'b1, 4'b0000, 3'd0, 7'h23);
    repeat (16) @(negedge clk);

    // AND output stuck at 0: only vector 11 differs
    fault_a = 1'b1;
    start_run(1'b0, 13, 1'b0, 4'b1000, 3'd1, 7'h22);
    repeat (16) @(negedge clk);
    fault_a = 1'b0;

    // Start re-pulsed in 3rd run cycle and in DONE cycle; busy held throughout
    start_run(1'b0, 13, 1'b1, 4'b0000, 3'd0, 7'h23);
    for (int unsigned i = 1; i <= 13; i++) begin
      chk("a_busy_run", ifa.busy, 1);
      ifa.start = (i == 3 || i == 13);
      @(negedge clk);
    end
    ifa.start = 1'b0;
    chk("a_busy_after", ifa.busy, 0);
    repeat (14) @(negedge clk);

    // Start and abort together in IDLE: start dropped, previous pass kept
    ifa.start = 1'b1; ifa.abort = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifa.abort = 1'b0;
    chk("a_startabort_busy", ifa.busy, 0);
    chk("a_startabort_pass", ifa.pass, 1);

    // Abort during vector 1 SETTLE
    kick_a();
    repeat (3) @(negedge clk);
    chk("a_pre_abort_busy",   ifa.busy,   1);
    chk("a_pre_abort_gate_b", ifa.gate_b, 1);
    ifa.abort = 1'b1;
    @(negedge clk);
    ifa.abort = 1'b0;
    chk("a_abort_busy",      ifa.busy,      0);
    chk("a_abort_gate_a",    ifa.gate_a,    0);
    chk("a_abort_gate_b",    ifa.gate_b,    0);
    chk("a_abort_fail_mask", ifa.fail_mask, 0);
    chk("a_abort_pass",      ifa.pass,      0);
    chk("a_abort_last_y",    ifa.last_y,    7'h6C);
    repeat (16) @(negedge clk);

    // Reset pulse during vector 1 CHECK, then a clean run
    kick_a();
    repeat (5) @(negedge clk);
    chk("a_pre_rst_busy",   ifa.busy,   1);
    chk("a_pre_rst_last_y", ifa.last_y, 7'h6C);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_a("a_mid_reset");
    start_run(1'b0, 13, 1'b1, 4'b0000, 3'd0, 7'h23);
    repeat (16) @(negedge clk);

    // SETTLE_CYCLES=1, gate_y stuck at zero
    start_run(1'b1, 9, 1'b0, 4'hF, 3'd4, 7'h00);
    repeat (14) @(negedge clk);

    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
